// File: rtl/order_judge.sv
// Round controller behind the bit-compare stage: scores stable matches, runs the
// BCD countdown, requests new target patterns and drives the hint LEDs.
module order_judge #(
   parameter int TICK_DIV   = 50_000_000,
   parameter int ROUND_SECS = 30,
   parameter int MATCH_HOLD = 4,
   parameter int SETTLE_MAX = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] change,
   input  logic       advance,
   input  logic       practicle,
   input  logic       start,
   output logic [9:0] hint_led,
   output logic [7:0] score_bcd,
   output logic [7:0] time_bcd,
   output logic       new_order,
   output logic       game_over,
   output logic [1:0] state
);
   localparam int TW = $clog2(TICK_DIV);
   localparam int MW = $clog2(MATCH_HOLD + 1);
   localparam int SW = $clog2(SETTLE_MAX + 1);
   localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
   localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_HOLD - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_MAX - 1);
   localparam logic [7:0]    ROUND_BCD   = 8'(((ROUND_SECS / 10) << 4) | (ROUND_SECS % 10));

   typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_SETTLE = 2'b10, S_OVER = 2'b11} state_t;

   state_t        r_state;
   logic [TW-1:0] r_tick;
   logic [MW-1:0] r_match;
   logic [SW-1:0] r_settle;

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      else                return {v[7:4], v[3:0] - 4'd1};
   endfunction

   function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
      if (v == 8'h99)          return v;
      else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                     return {v[7:4], v[3:0] + 4'd1};
   endfunction

   logic       w_active, w_timed, w_full, w_tick_wrap, w_final, w_match, w_settle_exit;
   logic [7:0] w_time_dec, w_score_inc;
   logic [9:0] w_hint;

   assign w_active      = advance | practicle;
   assign w_timed       = advance;
   assign w_full        = (change == 4'hF);
   assign w_tick_wrap   = w_timed && (r_tick == TICK_LAST);
   assign w_time_dec    = bcd_dec(time_bcd);
   // Last second expiring takes the round to OVER even if a match lands in the same cycle
   assign w_final       = w_tick_wrap && (w_time_dec == 8'h00);
   assign w_match       = (r_state == S_PLAY) && w_full && (r_match == MATCH_LAST);
   assign w_settle_exit = !w_full || (r_settle == SETTLE_LAST);
   assign w_score_inc   = bcd_inc_sat(score_bcd);
   assign w_hint        = (change <= 4'd9) ? (10'b1 << change) : 10'b0;
   assign state         = r_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_tick    <= '0;
         r_match   <= '0;
         r_settle  <= '0;
         hint_led  <= '0;
         score_bcd <= 8'h00;
         time_bcd  <= ROUND_BCD;
         new_order <= 1'b0;
         game_over <= 1'b0;
      end else begin
         new_order <= 1'b0;
         if (!w_active) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_match   <= '0;
            r_settle  <= '0;
            hint_led  <= '0;
            time_bcd  <= ROUND_BCD;
            game_over <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE, S_OVER: begin
                  hint_led <= '0;
                  if (start) begin
                     r_state   <= S_PLAY;
                     r_tick    <= '0;
                     r_match   <= '0;
                     r_settle  <= '0;
                     score_bcd <= 8'h00;
                     time_bcd  <= ROUND_BCD;
                     new_order <= 1'b1;
                     game_over <= 1'b0;
                  end
               end
               default: begin
                  hint_led <= w_hint;
                  if (w_timed) begin
                     r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
                     if (w_tick_wrap) time_bcd <= w_time_dec;
                  end
                  if (w_match) score_bcd <= w_score_inc;
                  if (r_state == S_PLAY) r_match <= (w_full && !w_match) ? r_match + 1'b1 : '0;
                  else                   r_settle <= r_settle + 1'b1;
                  if (w_final) begin
                     r_state   <= S_OVER;
                     game_over <= 1'b1;
                     hint_led  <= '0;
                  end else if (w_match) begin
                     r_state   <= S_SETTLE;
                     r_settle  <= '0;
                     new_order <= 1'b1;
                  end else if (r_state == S_SETTLE && w_settle_exit) begin
                     r_state <= S_PLAY;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_order_judge.sv
// Bench for order_judge: vector table, hand sequences for timing corners, and
// randomized stimulus against an integer-level reference model.
module tb_order_judge;
   localparam int TD = 4, RS = 5, MH = 3, SM = 8;
   localparam int ST_IDLE = 0, ST_PLAY = 1, ST_SETTLE = 2, ST_OVER = 3;

   logic       clk = 1'b0, reset = 1'b1;
   logic [3:0] change = 4'hE;
   logic       advance = 1'b0, practicle = 1'b0, start = 1'b0;
   logic [9:0] hint_led;
   logic [7:0] score_bcd, time_bcd;
   logic       new_order, game_over;
   logic [1:0] state;

   order_judge #(.TICK_DIV(TD), .ROUND_SECS(RS), .MATCH_HOLD(MH), .SETTLE_MAX(SM)) dut (
      .clk(clk), .reset(reset), .change(change), .advance(advance), .practicle(practicle),
      .start(start), .hint_led(hint_led), .score_bcd(score_bcd), .time_bcd(time_bcd),
      .new_order(new_order), .game_over(game_over), .state(state));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integers for seconds, score and run lengths
   int m_st, m_score, m_secs, m_tick, m_run, m_settle, m_new, m_hint;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   task automatic model_reset();
      m_st = ST_IDLE; m_score = 0; m_secs = RS; m_tick = 0; m_run = 0; m_settle = 0;
      m_new = 0; m_hint = 0;
   endtask

   task automatic model_step();
      bit hit, final_sec, leave;
      m_new = 0;
      if (!(advance || practicle)) begin
         m_st = ST_IDLE; m_tick = 0; m_run = 0; m_settle = 0; m_secs = RS; m_hint = 0;
      end else if (m_st == ST_IDLE || m_st == ST_OVER) begin
         m_hint = 0;
         if (start) begin
            m_st = ST_PLAY; m_score = 0; m_secs = RS; m_tick = 0; m_run = 0; m_new = 1;
         end
      end else begin
         hit = 0; final_sec = 0; leave = 0;
         if (advance) begin
            m_tick++;
            if (m_tick == TD) begin
               m_tick = 0; m_secs--; final_sec = (m_secs == 0);
            end
         end
         if (m_st == ST_PLAY) begin
            m_run = (change == 4'hF) ? m_run + 1 : 0;
            if (m_run == MH) begin hit = 1; m_run = 0; end
         end else begin
            m_settle++;
            leave = (change != 4'hF) || (m_settle == SM);
         end
         if (hit && m_score < 99) m_score++;
         if (final_sec) m_st = ST_OVER;
         else if (hit) begin m_st = ST_SETTLE; m_settle = 0; m_new = 1; end
         else if (leave) m_st = ST_PLAY;
         m_hint = (m_st != ST_OVER && change <= 9) ? (1 << change) : 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, ".state"}, 32'(state), 32'(m_st));
      chk({tag, ".time"},  32'(time_bcd), 32'(to_bcd(m_secs)));
      chk({tag, ".score"}, 32'(score_bcd), 32'(to_bcd(m_score)));
      chk({tag, ".new"},   32'(new_order), 32'(m_new));
      chk({tag, ".hint"},  32'(hint_led), 32'(m_hint));
      chk({tag, ".over"},  32'(game_over), 32'(m_st == ST_OVER));
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; start = 1'b0;
      #3;
      reset = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic [3:0] ch;
      logic       st;
      logic [1:0] e_state;
      logic [7:0] e_time, e_score;
      logic       e_new;
      logic [9:0] e_hint;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int n, pulses;
      logic prev_new;
      tbl[0] = '{4'hE, 1'b1, 2'd1, 8'h05, 8'h00, 1'b1, 10'h000};
      tbl[1] = '{4'h3, 1'b0, 2'd1, 8'h05, 8'h00, 1'b0, 10'h008};
      tbl[2] = '{4'hF, 1'b0, 2'd1, 8'h05, 8'h00, 1'b0, 10'h000};
      tbl[3] = '{4'h3, 1'b0, 2'd1, 8'h05, 8'h00, 1'b0, 10'h008};
      tbl[4] = '{4'hF, 1'b0, 2'd1, 8'h04, 8'h00, 1'b0, 10'h000};
      tbl[5] = '{4'hF, 1'b0, 2'd1, 8'h04, 8'h00, 1'b0, 10'h000};
      tbl[6] = '{4'hF, 1'b0, 2'd2, 8'h04, 8'h01, 1'b1, 10'h000};
      tbl[7] = '{4'h2, 1'b0, 2'd1, 8'h04, 8'h01, 1'b0, 10'h004};
      tbl[8] = '{4'hE, 1'b0, 2'd1, 8'h03, 8'h01, 1'b0, 10'h000};

      // Reset values
      @(posedge clk); @(posedge clk); #1;
      chk("rst.state", 32'(state), 0);
      chk("rst.time", 32'(time_bcd), 32'h05);
      chk("rst.score", 32'(score_bcd), 0);
      chk("rst.hint", 32'(hint_led), 0);
      chk("rst.new", 32'(new_order), 0);
      chk("rst.over", 32'(game_over), 0);
      reset = 1'b0;
      model_reset();

      // Start, hint blink, first score and SETTLE exit
      advance = 1'b1;
      for (int i = 0; i < 9; i++) begin
         change = tbl[i].ch; start = tbl[i].st;
         step();
         chk($sformatf("vec%0d.state", i), 32'(state), 32'(tbl[i].e_state));
         chk($sformatf("vec%0d.time", i), 32'(time_bcd), 32'(tbl[i].e_time));
         chk($sformatf("vec%0d.score", i), 32'(score_bcd), 32'(tbl[i].e_score));
         chk($sformatf("vec%0d.new", i), 32'(new_order), 32'(tbl[i].e_new));
         chk($sformatf("vec%0d.hint", i), 32'(hint_led), 32'(tbl[i].e_hint));
      end

      // Countdown to OVER, then restart
      change = 4'hE; start = 1'b0; n = 0;
      while (state != 2'd3 && n < 40) begin step(); n++; end
      chk("over.reached", 32'(n < 40), 1);
      chk("over.state", 32'(state), 3);
      chk("over.time", 32'(time_bcd), 0);
      chk("over.flag", 32'(game_over), 1);
      chk("over.hint", 32'(hint_led), 0);
      chk("over.score", 32'(score_bcd), 32'h01);
      start = 1'b1; step(); start = 1'b0;
      chk("restart.state", 32'(state), 1);
      chk("restart.time", 32'(time_bcd), 32'h05);
      chk("restart.score", 32'(score_bcd), 0);
      chk("restart.new", 32'(new_order), 1);
      step();
      chk("restart.new_drop", 32'(new_order), 0);

      // Mid-round reset is asynchronous and emits no pulse
      change = 4'hF; step(); step();
      #2 reset = 1'b1; #1;
      chk("midrst.state", 32'(state), 0);
      chk("midrst.time", 32'(time_bcd), 32'h05);
      chk("midrst.new", 32'(new_order), 0);
      #1 reset = 1'b0;
      model_reset();

      // Practice mode: held match scores once per SETTLE_MAX+MATCH_HOLD window, timer frozen
      advance = 1'b0; practicle = 1'b1; change = 4'hE;
      start = 1'b1; step(); start = 1'b0; step();
      change = 4'hF; pulses = 0; prev_new = 1'b0;
      for (int i = 0; i < 22; i++) begin
         step();
         cmp_model("hold");
         if (new_order) pulses++;
         chk("hold.no_double", 32'(prev_new & new_order), 0);
         prev_new = new_order;
      end
      chk("hold.pulses", pulses, 2);
      chk("hold.score", 32'(score_bcd), 32'h02);
      change = 4'hE;
      for (int i = 0; i < 40; i++) step();
      chk("prac.time", 32'(time_bcd), 32'h05);
      chk("prac.state", 32'(state), 1);
      practicle = 1'b0; step();
      chk("prac.drop", 32'(state), 0);
      chk("prac.drop_score", 32'(score_bcd), 32'h02);

      // Score saturation at 99
      practicle = 1'b1; start = 1'b1; step(); start = 1'b0;
      change = 4'hF;
      for (int i = 0; i < 1150; i++) step();
      chk("sat.score", 32'(score_bcd), 32'h99);
      cmp_model("sat");

      // Randomized run against the model
      do_reset();
      prev_new = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         change    = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         advance   = ($urandom_range(0, 7) != 0);
         practicle = 1'($urandom_range(0, 1));
         start     = ($urandom_range(0, 11) == 0);
         step();
         cmp_model("rnd");
         chk("rnd.no_double", 32'(prev_new & new_order), 0);
         prev_new = new_order;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
